shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Serial-in / parallel-out receiver: the receive end of the shift-register serial link whose transmit side is built from D flip-flop shifting stages.
- Captures one bit per SIN_VALID strobe into a shift register and counts bits, aligned by a SYNC pulse.
- Each completed word is presented on a valid/ready parallel output register; shifting continues while that register is held.
- Runs on the 50 MHz system clock.

Parameters:
- WIDTH, 8, data word width in bits (2..32).
- MSB_FIRST, 1, 1: first received bit lands in DOUT[WIDTH-1]; 0: first bit lands in DOUT[0].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- SIN  input  1  serial data bit.
- SIN_VALID  input  1  SIN is sampled on this edge when high.
- SYNC  input  1  one-cycle frame-alignment pulse; restarts bit count.
- DOUT  output  WIDTH  last completed word.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT on this edge when DOUT_VALID=1.
- OVERRUN  output  1  one-cycle pulse: completed word dropped.
- BIT_CNT  output  $clog2(WIDTH+2)  bits received in current frame.
- PERR  output  1  parity error flag for DOUT (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-frame):
  - DOUT=0, DOUT_VALID=0, OVERRUN=0, PERR=0, BIT_CNT=0.
  - Shift register cleared; state=IDLE; any partial word discarded.
- States:
  - IDLE (unaligned): SIN_VALID ignored while SYNC=0.
  - SHIFT (aligned): entered on SYNC=1; left only by reset.
- SYNC=1 (either state): BIT_CNT restarts, partial word discarded, state->SHIFT.
  - If SIN_VALID=1 in the same cycle, that SIN is bit 0 of the new frame and BIT_CNT=1 next cycle; otherwise BIT_CNT=0.
- In SHIFT, SIN_VALID=1 and SYNC=0: shift SIN in and increment BIT_CNT. Gaps of any length between strobes are allowed.
- Frame length is FL = WIDTH (FL = WIDTH+1 with PARITY_CHECK_EN).
- Completion: the edge that accepts bit FL-1.
  - BIT_CNT returns to 0 and the state stays in SHIFT (streaming; the next strobe is bit 0 of the next word, with no SYNC needed).
  - The assembled word is offered to the output register on that same edge, so DOUT/DOUT_VALID update 1 cycle after the last bit's strobe cycle.
- Output register rules, evaluated on each edge:
  - DOUT_VALID=1 and DOUT_READY=1, no completion: DOUT_VALID->0; DOUT holds its value.
  - Completion with DOUT_VALID=0: load DOUT, DOUT_VALID->1.
  - Completion with DOUT_VALID=1 and DOUT_READY=1: load the new word, DOUT_VALID stays 1, no overrun.
  - Completion with DOUT_VALID=1 and DOUT_READY=0: new word dropped, DOUT unchanged, OVERRUN=1 for exactly one cycle.
- DOUT_READY is ignored while DOUT_VALID=0.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit; completion occurs on the parity bit.
  - PERR loads with DOUT: 1 if the XOR of the data bits and the parity bit is 1.
  - On overrun, PERR is dropped along with the word; otherwise PERR holds with DOUT.
  - PERR is cleared when DOUT_VALID falls.
- Not defined: frame = WIDTH bits; PERR tied to 0; no parity logic synthesized.

Test Plan:
- Hold RST=1 5 cycles, then release, then 8 SIN_VALID strobes of SIN=1 with no SYNC -> DOUT=0x00, DOUT_VALID=0, BIT_CNT=0 throughout.
- SYNC with first strobe, bits 1,0,1,0,0,1,0,1 on consecutive cycles, DOUT_READY=1 (WIDTH=8, MSB_FIRST=1) -> DOUT=0xA5; DOUT_VALID high 1 cycle after the 8th strobe for exactly one cycle. Repeat with MSB_FIRST=0 -> DOUT=0xA5.
- After 0xA5 with DOUT_READY=0, stream 0x3C then 0xFF without SYNC -> DOUT stays 0xA5 and DOUT_VALID stays 1; OVERRUN pulses one cycle at 0x3C completion and again at 0xFF completion; DOUT_READY=1 -> DOUT_VALID drops the next edge.
- Send 0xA5 with 5-cycle gaps between strobes -> DOUT=0xA5, same 1-cycle latency after the last strobe.
- 3 bits of a frame, then SYNC plus 8 bits of 1 -> DOUT=0xFF; the partial bits have no effect. Also 4 bits, then RST pulse, then SYNC + 0x0F -> DOUT=0x0F, no earlier word emitted.
- With PARITY_CHECK_EN: 0xA5 + parity 0 -> DOUT=0xA5, PERR=0; 0xA5 + parity 1 -> PERR=1. PERR clears after the handshake.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// rtl/shift_deserializer_if.sv - serial input and parallel valid/ready output bundle for shift_deserializer
interface shift_deserializer_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 2);

  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;
  logic             perr;

  // master: the deserializer itself; slave: the serial source plus word consumer
  modport master (
    input  sin, sin_valid, sync, dout_ready,
    output dout, dout_valid, overrun, bit_cnt, perr
  );

  modport slave (
    output sin, sin_valid, sync, dout_ready,
    input  dout, dout_valid, overrun, bit_cnt, perr
  );
endinterface

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - SYNC-aligned serial-in/parallel-out receiver with valid/ready output register
// Optional even-parity frame check enabled by defining PARITY_CHECK_EN.
module shift_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shift_deserializer_if.master  bus
);

`ifdef PARITY_CHECK_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic [WIDTH-1:0] word;
`ifdef PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic             perr_new;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // Alignment and bit counting; the last accepted bit of a frame raises complete
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    complete = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d    = par_q;
    word     = sh_q;
    perr_new = par_q ^ bus.sin;
`else
    word     = shift_in(sh_q, bus.sin);
`endif
    if (bus.sync) begin
      state_d = ST_SHIFT;
      if (bus.sin_valid) begin
        cnt_d = CW'(1);
        sh_d  = shift_in('0, bus.sin);
`ifdef PARITY_CHECK_EN
        par_d = bus.sin;
`endif
      end else begin
        cnt_d = '0;
        sh_d  = '0;
`ifdef PARITY_CHECK_EN
        par_d = 1'b0;
`endif
      end
    end else if (state_q == ST_SHIFT && bus.sin_valid) begin
      if (cnt_q == CW'(FL - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        sh_d     = '0;
`ifdef PARITY_CHECK_EN
        par_d    = 1'b0;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
`ifdef PARITY_CHECK_EN
        par_d = par_q ^ bus.sin;
        // the parity bit never enters the data shift register
        sh_d  = shift_in(sh_q, bus.sin);
`else
        sh_d  = shift_in(sh_q, bus.sin);
`endif
      end
    end
  end

  // Output register: a completion with an unconsumed, unaccepted word is dropped
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    if (complete) begin
      if (!valid_q || bus.dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        perr_d  = perr_new;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.bit_cnt    = cnt_q;
`ifdef PARITY_CHECK_EN
  assign bus.perr       = perr_q;
`else
  assign bus.perr       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - self-checking bench for shift_deserializer (MSB-first and LSB-first instances)
module tb_shift_deserializer;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);
`ifdef PARITY_CHECK_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sin  = 1'b0;
  logic sv   = 1'b0;
  logic sync = 1'b0;
  logic rdy  = 1'b0;

  int errors = 0;
  int checks = 0;

  shift_deserializer_if #(.WIDTH(W)) if_m ();
  shift_deserializer_if #(.WIDTH(W)) if_l ();

  assign if_m.sin        = sin;
  assign if_m.sin_valid  = sv;
  assign if_m.sync       = sync;
  assign if_m.dout_ready = rdy;
  assign if_l.sin        = sin;
  assign if_l.sin_valid  = sv;
  assign if_l.sync       = sync;
  assign if_l.dout_ready = rdy;

  shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_m.master)
  );

  shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_l.master)
  );

  always #10 clk = ~clk;

  // Reference model: received bits of the current frame kept as a list
  bit           aligned;
  bit           frame[$];
  logic [W-1:0] e_dout_m, e_dout_l;
  logic         e_valid, e_ovr, e_perr;

  task automatic model_reset();
    aligned  = 1'b0;
    frame.delete();
    e_dout_m = '0;
    e_dout_l = '0;
    e_valid  = 1'b0;
    e_ovr    = 1'b0;
    e_perr   = 1'b0;
  endtask

  task automatic cycle(input logic b, input logic v, input logic s, input logic r);
    logic [W-1:0] wm, wl;
    logic         pe;
    bit           done;
    sin  = b;
    sv   = v;
    sync = s;
    rdy  = r;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    pe   = 1'b0;
    if (s) begin
      aligned = 1'b1;
      frame.delete();
      if (v) frame.push_back(b);
    end else if (aligned && v) begin
      frame.push_back(b);
      if (frame.size() == FL) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm = wm | (W'(frame[i]) << (W - 1 - i));
          wl = wl | (W'(frame[i]) << i);
        end
        for (int i = 0; i < FL; i++) pe = pe ^ frame[i];
        frame.delete();
      end
    end
    e_ovr = 1'b0;
    if (done) begin
      if (!e_valid || r) begin
        e_dout_m = wm;
        e_dout_l = wl;
        e_valid  = 1'b1;
`ifdef PARITY_CHECK_EN
        e_perr   = pe;
`endif
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_valid && r) begin
      e_valid = 1'b0;
      e_perr  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Word w is sent first-bit = w[W-1]; pbit is appended when parity framing is on
  task automatic send_word(input logic [W-1:0] w, input int gap, input bit with_sync,
                           input logic r, input logic pbit);
    logic b;
    for (int i = 0; i < FL; i++) begin
      if (i < W) b = w[W-1-i];
      else       b = pbit;
      cycle(b, 1'b1, with_sync && (i == 0), r);
      if (i < FL - 1) repeat (gap) cycle(1'b0, 1'b0, 1'b0, r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (if_m.dout !== '0) begin errors++; $display("FAIL reset_dout: got %0h want 0", if_m.dout); end
    checks++;
    if (if_m.dout_valid !== 1'b0 || if_l.dout_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b want 0", if_m.dout_valid, if_l.dout_valid);
    end
    checks++;
    if (if_m.bit_cnt !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d want 0", if_m.bit_cnt); end
    checks++;
    if (if_m.overrun !== 1'b0 || if_m.perr !== 1'b0) begin
      errors++; $display("FAIL reset_flags: overrun %b perr %b want 0 0", if_m.overrun, if_m.perr);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (if_m.dout_valid !== 1'b0 || if_m.bit_cnt !== '0 || if_m.dout !== '0) begin
        errors++;
        $display("FAIL unaligned_ignore[%0d]: valid %b cnt %0d dout %0h want 0 0 0",
                 i, if_m.dout_valid, if_m.bit_cnt, if_m.dout);
      end
    end
  endtask

  task automatic test_basic();
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if_m.dout !== 8'hA5 || if_m.dout_valid !== 1'b1) begin
      errors++; $display("FAIL basic_msb: dout %0h valid %b want a5 1", if_m.dout, if_m.dout_valid);
    end
    checks++;
    if (if_l.dout !== 8'hA5 || if_l.dout_valid !== 1'b1) begin
      errors++; $display("FAIL basic_lsb: dout %0h valid %b want a5 1", if_l.dout, if_l.dout_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.dout_valid !== 1'b0 || if_m.dout !== 8'hA5) begin
      errors++; $display("FAIL basic_consume: valid %b dout %0h want 0 a5", if_m.dout_valid, if_m.dout);
    end
  endtask

  task automatic test_overrun();
    send_word(8'hA5, 0, 1'b1, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (if_m.overrun !== 1'b1 || if_l.overrun !== 1'b1 || if_m.dout !== 8'hA5 || if_m.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_3c: ovr %b/%b dout %0h valid %b want 1/1 a5 1",
               if_m.overrun, if_l.overrun, if_m.dout, if_m.dout_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (if_m.overrun !== 1'b0 || if_m.dout_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse: ovr %b valid %b want 0 1", if_m.overrun, if_m.dout_valid);
    end
    send_word(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (if_m.overrun !== 1'b1 || if_m.dout !== 8'hA5) begin
      errors++; $display("FAIL overrun_ff: ovr %b dout %0h want 1 a5", if_m.overrun, if_m.dout);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.dout_valid !== 1'b0 || if_m.overrun !== 1'b0 || if_m.dout !== 8'hA5) begin
      errors++;
      $display("FAIL overrun_release: valid %b ovr %b dout %0h want 0 0 a5",
               if_m.dout_valid, if_m.overrun, if_m.dout);
    end
  endtask

  task automatic test_gaps();
    send_word(8'hA5, 5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (if_m.dout !== 8'hA5 || if_m.dout_valid !== 1'b1 || if_m.bit_cnt !== '0) begin
      errors++;
      $display("FAIL gaps_word: dout %0h valid %b cnt %0d want a5 1 0",
               if_m.dout, if_m.dout_valid, if_m.bit_cnt);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.dout_valid !== 1'b0) begin errors++; $display("FAIL gaps_consume: valid %b want 0", if_m.dout_valid); end
  endtask

  task automatic test_resync();
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (if_m.bit_cnt !== CW'(3)) begin errors++; $display("FAIL partial_cnt: got %0d want 3", if_m.bit_cnt); end
    send_word(8'hFF, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if_m.dout !== 8'hFF || if_l.dout !== 8'hFF || if_m.dout_valid !== 1'b1) begin
      errors++; $display("FAIL resync_ff: dout %0h/%0h valid %b want ff/ff 1", if_m.dout, if_l.dout, if_m.dout_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (if_m.bit_cnt !== CW'(4)) begin errors++; $display("FAIL partial4_cnt: got %0d want 4", if_m.bit_cnt); end
    sv = 1'b0;
    #3 rst = 1'b1;
    #2;
    checks++;
    if (if_m.bit_cnt !== '0 || if_m.dout !== '0 || if_m.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt %0d dout %0h valid %b want 0 0 0", if_m.bit_cnt, if_m.dout, if_m.dout_valid);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < FL; i++) begin
      logic b;
      if (i < W) b = (8'h0F >> (W - 1 - i)) & 1'b1;
      else       b = 1'b0;
      cycle(b, 1'b1, i == 0, 1'b1);
      if (i < FL - 1) begin
        checks++;
        if (if_m.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_no_word[%0d]: valid %b want 0", i, if_m.dout_valid); end
      end
    end
    checks++;
    if (if_m.dout !== 8'h0F || if_l.dout !== 8'hF0 || if_m.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_0f: dout %0h/%0h valid %b want 0f/f0 1", if_m.dout, if_l.dout, if_m.dout_valid);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    send_word(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (if_m.dout !== 8'hA5 || if_m.perr !== 1'b0) begin
      errors++; $display("FAIL parity_good: dout %0h perr %b want a5 0", if_m.dout, if_m.perr);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hA5, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.perr !== 1'b1 || if_l.perr !== 1'b1) begin
      errors++; $display("FAIL parity_bad: perr %b/%b want 1", if_m.perr, if_l.perr);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (if_m.perr !== 1'b1) begin errors++; $display("FAIL parity_hold: perr %b want 1", if_m.perr); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (if_m.perr !== 1'b0 || if_m.dout_valid !== 1'b0) begin
      errors++; $display("FAIL parity_clear: perr %b valid %b want 0 0", if_m.perr, if_m.dout_valid);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom % 2), 1'(($urandom % 4) != 0), 1'(($urandom % 50) == 0), 1'($urandom % 2));
      checks++;
      if ({if_m.dout, if_l.dout, if_m.dout_valid, if_l.dout_valid, if_m.overrun, if_l.overrun,
           if_m.bit_cnt, if_l.bit_cnt, if_m.perr}
          !== {e_dout_m, e_dout_l, e_valid, e_valid, e_ovr, e_ovr,
               CW'(frame.size()), CW'(frame.size()), e_perr}) begin
        errors++;
        $display("FAIL random[%0d]: dout %0h/%0h valid %b ovr %b cnt %0d perr %b want %0h/%0h %b %b %0d %b",
                 n, if_m.dout, if_l.dout, if_m.dout_valid, if_m.overrun, if_m.bit_cnt, if_m.perr,
                 e_dout_m, e_dout_l, e_valid, e_ovr, frame.size(), e_perr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_gaps();
    test_resync();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
